// File: rtl/bcd_digit_counter.sv
`timescale 1ns/1ps
// bcd_digit_counter
//   Prescaled, cascadable up-counter for one display digit. The 4-bit value
//   counts 0..MAX_COUNT and wraps. It is controlled by start/pause/clr/load
//   and feeds a seven-segment decoder directly.
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-low reset
//   start    - pulse: STOP/PAUSE -> RUN
//   pause    - pulse: RUN -> PAUSE (wins over start)
//   clr      - synchronous clear to 0 / STOP
//   load     - synchronous load of load_val (saturated to MAX_COUNT)
//   load_val - value to load
//   cin      - cascade enable; a step needs tick && cin
//   value    - registered count
//   tc       - registered value == MAX_COUNT
//   cout     - combinational: step && value == MAX_COUNT (next digit's cin)
//   running  - registered state == RUN
module bcd_digit_counter #(
  parameter int unsigned PRESCALE   = 25_000_000,
  parameter int unsigned PRESCALE_W = 25,
  parameter int unsigned MAX_COUNT  = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       cin,
  output logic [3:0] value,
  output logic       tc,
  output logic       cout,
  output logic       running
);

  localparam logic [1:0] ST_STOP  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam logic [3:0]            MAX_VAL    = 4'(MAX_COUNT);
  localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(PRESCALE - 1);

  logic [1:0]            state_q, state_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [3:0]            value_q, value_d;
  logic                  tc_q, tc_d;
  logic                  running_q, running_d;

  logic       is_run_c;
  logic       tick_c;
  logic       at_max_c;
  logic       step_c;
  logic [3:0] load_sat_c;

  // Step decode; clr and load both suppress the step (and therefore cout).
  always_comb begin
    is_run_c   = (state_q == ST_RUN);
    tick_c     = is_run_c && (presc_q == PRESC_LAST);
    at_max_c   = (value_q == MAX_VAL);
    step_c     = tick_c && cin && !clr && !load;
    load_sat_c = (load_val > MAX_VAL) ? MAX_VAL : load_val;
  end

  // Next state: clr > load > pause/start > step.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    value_d = value_q;
    if (clr) begin
      state_d = ST_STOP;
      presc_d = '0;
      value_d = 4'd0;
    end else if (load) begin
      presc_d = '0;
      value_d = load_sat_c;
    end else begin
      if (pause) begin
        if (is_run_c) begin
          state_d = ST_PAUSE;
        end
      end else if (start && !is_run_c) begin
        state_d = ST_RUN;
        // Resuming from PAUSE keeps the held prescaler; STOP starts fresh.
        if (state_q != ST_PAUSE) begin
          presc_d = '0;
        end
      end
      // A RUN cycle always counts, even the one in which pause is accepted.
      if (is_run_c) begin
        presc_d = tick_c ? '0 : presc_q + PRESCALE_W'(1);
      end
      if (step_c) begin
        value_d = at_max_c ? 4'd0 : value_q + 4'd1;
      end
    end
    tc_d      = (value_d == MAX_VAL);
    running_d = (state_d == ST_RUN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_STOP;
      presc_q   <= '0;
      value_q   <= 4'd0;
      tc_q      <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      value_q   <= value_d;
      tc_q      <= tc_d;
      running_q <= running_d;
    end
  end

  assign value   = value_q;
  assign tc      = tc_q;
  assign running = running_q;
  assign cout    = step_c && at_max_c;

endmodule
